prog_sequencer: RTL
===================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter PCW, default 10, program-counter width.
REQ-002 Parameter PC1_START, default 10'd0, entry address of program 1 (Hamming encode).
REQ-003 Parameter PC2_START, default 10'd100, entry address of program 2 (Hamming decode/correct).
REQ-004 Parameter PC3_START, default 10'd200, entry address of program 3 (pattern count).
REQ-005 Parameter TIMEOUT_CYCLES, default 4096, watchdog limit on RUN cycles.
REQ-006 CLK  input  1  single system clock, all flops rising-edge.
REQ-007 Reset_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  request from bench/host; one or more cycles high.
REQ-009 halt  input  1  core signals end of current program; level, sampled only in RUN.
REQ-010 run  output  1  core enable; core fetches/executes only while high.
REQ-011 pc_load  output  1  one-cycle strobe; core PC takes pc_init.
REQ-012 pc_init  output  PCW  entry address for the selected program.
REQ-013 prog_id  output  2  program running or last run: 0 none, 1..3.
REQ-014 done  output  1  ack to requester; level, held until next accepted start.
REQ-015 timeout  output  1  last program ended by watchdog, not by halt.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, RUN, DONE.
REQ-017 A start is accepted only on a rising edge (start=1 and registered start_q=0) sampled in IDLE or DONE.
REQ-018 Accepted start SHALL move FSM to LOAD on the next edge; done and timeout drop to 0 in that same cycle.
REQ-019 On entering LOAD, prog_id SHALL advance 0->1, 1->2, 2->3, 3->1 (wrap).
REQ-020 In LOAD, pc_load=1 for exactly one cycle, pc_init = PCn_START selected by the new prog_id, run=0.
REQ-021 LOAD SHALL go to RUN unconditionally; run=1 from the first RUN cycle, i.e. two cycles after the accepting edge.
REQ-022 In RUN, halt=1 SHALL move FSM to DONE on the next edge; run=0, done=1 from that cycle.
REQ-023 A 16-bit watchdog counter SHALL clear in LOAD and increment each RUN cycle; when it equals TIMEOUT_CYCLES-1 with halt=0, FSM goes to DONE with timeout=1.
REQ-024 halt and watchdog expiry in the same cycle: halt wins, timeout=0.
REQ-025 start edges in LOAD or RUN SHALL be ignored and not queued.
REQ-026 halt in IDLE, LOAD or DONE SHALL be ignored.
REQ-027 A start held high across DONE SHALL NOT retrigger; a fresh rising edge is required.
REQ-028 pc_init SHALL hold its last value outside LOAD; in IDLE after reset it is 0.
REQ-029 All outputs SHALL be registered; no combinational path from start or halt to any output.

Reset
REQ-030 Reset_n=0 SHALL asynchronously force IDLE, run=0, pc_load=0, pc_init=0, prog_id=0, done=0, timeout=0, start_q=0, watchdog=0.
REQ-031 Reset asserted mid-RUN SHALL abort the program; after release the next accepted start runs program 1.
REQ-032 Reset release is synchronised internally (two-flop deassert) so the first edge after release is clean.

Structure
REQ-033 Package prog_seq_pkg SHALL hold the state enum, PCW default, PCn_START defaults and the prog_id encoding constants.
REQ-034 One sub-module, start_edge_det (registered rising-edge detector on start, async reset), SHALL be instantiated; all else stays in prog_sequencer.

Verification
REQ-035 Reset, start pulse 1 cycle: LOAD with pc_init=0, prog_id=1; run=1 two cycles after edge; halt after 20 cycles -> done=1, run=0, timeout=0.
REQ-036 Three start/halt rounds then a fourth: pc_init sequence 0, 100, 200, 0 and prog_id 1, 2, 3, 1.
REQ-037 TIMEOUT_CYCLES=8, halt never asserted: done=1 and timeout=1 exactly 8 RUN cycles after run rose; next start clears both.
REQ-038 start pulsed during RUN and held high through DONE: no restart, prog_id unchanged, done stays 1 until start falls and rises again.
REQ-039 Reset_n pulled low mid-RUN (asynchronously, between edges): run, done and prog_id go 0 immediately; next start gives prog_id=1.
REQ-040 halt and watchdog expiry in the same cycle (TIMEOUT_CYCLES=8, halt on 8th RUN cycle): done=1, timeout=0.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer.
// Holds the FSM state enum, PC defaults and prog_id encoding.
package prog_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    localparam int         PCW_DEF       = 10;
    localparam logic [9:0] PC1_START_DEF = 10'd0;
    localparam logic [9:0] PC2_START_DEF = 10'd100;
    localparam logic [9:0] PC3_START_DEF = 10'd200;

    localparam logic [1:0] PID_NONE = 2'd0;
    localparam logic [1:0] PID_P1   = 2'd1;
    localparam logic [1:0] PID_P2   = 2'd2;
    localparam logic [1:0] PID_P3   = 2'd3;

    // Round-robin over the three programs; "none" starts at program 1.
    function automatic logic [1:0] next_prog(input logic [1:0] id);
        logic [1:0] nid;
        unique case (id)
            PID_NONE: nid = PID_P1;
            PID_P1:   nid = PID_P2;
            PID_P2:   nid = PID_P3;
            PID_P3:   nid = PID_P1;
        endcase
        return nid;
    endfunction

endpackage

// File: rtl/prog_sequencer_start_edge_det.sv
// Registered rising-edge detector on the start request.
// rise is high while start=1 and the previous sample was 0.
module start_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic rise
);

    logic start_d;
    logic start_q;

    always_comb begin
        start_d = start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start_d;
        end
    end

    assign rise = start & ~start_q;

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: selects, launches and supervises one of
// three core programs per start request, with a RUN watchdog.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int             PCW            = PCW_DEF,
    parameter logic [PCW-1:0] PC1_START      = PCW'(PC1_START_DEF),
    parameter logic [PCW-1:0] PC2_START      = PCW'(PC2_START_DEF),
    parameter logic [PCW-1:0] PC3_START      = PCW'(PC3_START_DEF),
    parameter int             TIMEOUT_CYCLES = 4096
) (
    input  logic           CLK,
    input  logic           Reset_n,
    input  logic           start,
    input  logic           halt,
    output logic           run,
    output logic           pc_load,
    output logic [PCW-1:0] pc_init,
    output logic [1:0]     prog_id,
    output logic           done,
    output logic           timeout
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0] rst_sync_d;
    logic [1:0] rst_sync_q;
    logic       rst_n;
    logic       start_rise;

    state_e           state_d,   state_q;
    logic             run_d,     run_q;
    logic             pc_load_d, pc_load_q;
    logic [PCW-1:0]   pc_init_d, pc_init_q;
    logic [1:0]       prog_d,    prog_q;
    logic             done_d,    done_q;
    logic             tmo_d,     tmo_q;
    logic [15:0]      wd_d,      wd_q;

    function automatic logic [PCW-1:0] entry_pc(input logic [1:0] id);
        logic [PCW-1:0] pc;
        unique case (id)
            PID_P1:  pc = PC1_START;
            PID_P2:  pc = PC2_START;
            PID_P3:  pc = PC3_START;
            default: pc = '0;
        endcase
        return pc;
    endfunction

    // Assert asynchronously, release two edges after Reset_n rises.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    start_edge_det u_start_edge (
        .clk   (CLK),
        .rst_n (rst_n),
        .start (start),
        .rise  (start_rise)
    );

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        pc_load_d = 1'b0;
        pc_init_d = pc_init_q;
        prog_d    = prog_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        wd_d      = wd_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_rise) begin
                    state_d   = S_LOAD;
                    prog_d    = next_prog(prog_q);
                    pc_load_d = 1'b1;
                    pc_init_d = entry_pc(prog_d);
                    done_d    = 1'b0;
                    tmo_d     = 1'b0;
                    wd_d      = '0;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
                run_d   = 1'b1;
                wd_d    = '0;
            end
            S_RUN: begin
                wd_d = wd_q + 16'd1;
                // halt takes priority over a coincident expiry
                if (halt) begin
                    state_d = S_DONE;
                    run_d   = 1'b0;
                    done_d  = 1'b1;
                    tmo_d   = 1'b0;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_DONE;
                    run_d   = 1'b0;
                    done_d  = 1'b1;
                    tmo_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            pc_load_q <= 1'b0;
            pc_init_q <= '0;
            prog_q    <= PID_NONE;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            pc_load_q <= pc_load_d;
            pc_init_q <= pc_init_d;
            prog_q    <= prog_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            wd_q      <= wd_d;
        end
    end

    assign run     = run_q;
    assign pc_load = pc_load_q;
    assign pc_init = pc_init_q;
    assign prog_id = prog_q;
    assign done    = done_q;
    assign timeout = tmo_q;

endmodule
